leg_loader: RTL

LEG_LOADER -- requirements
Module: leg_loader

---
 rtl/leg_loader_if.sv | 21 ++
 rtl/leg_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/leg_loader_if.sv
// rtl/leg_loader_if.sv - byte stream in and memory write port of the leg loader
interface leg_loader_if #(
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/leg_loader.sv
// rtl/leg_loader.sv - frame loader: SYNC ADDR LEN DATA* CSUM into byte memory, then releases the cpu
module leg_loader #(
   parameter int          MEM_BYTES = 32,
   parameter int          ADDR_W    = 5,
   parameter logic [7:0]  SYNC      = 8'hA5
) (
   input  logic         clk,
   input  logic         rst,
   leg_loader_if.slave  bus,
   output logic         cpu_run,
   output logic [7:0]   entry_ip,
   output logic         load_ok,
   output logic         load_err
);
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] ADDR_MASK = 8'(MEM_BYTES - 1);

   state_t            r_state, w_next;
   logic              r_ready;
   logic [7:0]        r_frame_addr, r_len_cnt, r_sum;
   logic [ADDR_W-1:0] r_waddr;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;

   logic w_accept, w_take_sync, w_take_addr, w_take_len, w_take_data, w_take_csum;
   logic w_sum_match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_accept) begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: if (bus.in_data == SYNC) w_next = S_ADDR;
            S_ADDR:  w_next = S_LEN;
            S_LEN:   w_next = (bus.in_data == 8'd0) ? S_CSUM : S_DATA;
            S_DATA:  if (r_len_cnt == 8'd1) w_next = S_CSUM;
            S_CSUM:  w_next = w_sum_match ? S_DONE : S_ERR;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_accept    = bus.in_valid & r_ready;
      w_sum_match = (bus.in_data == r_sum);
      w_take_sync = w_accept && (bus.in_data == SYNC) &&
                    (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
      w_take_addr = w_accept && (r_state == S_ADDR);
      w_take_len  = w_accept && (r_state == S_LEN);
      w_take_data = w_accept && (r_state == S_DATA);
      w_take_csum = w_accept && (r_state == S_CSUM);
   end

   // r_ready stays low for the first edge after reset release so a byte presented then is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready      <= 1'b0;
         r_frame_addr <= 8'd0;
         r_len_cnt    <= 8'd0;
         r_sum        <= 8'd0;
         r_waddr      <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 8'd0;
         cpu_run      <= 1'b0;
         entry_ip     <= 8'h10;
         load_ok      <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         r_ready  <= 1'b1;
         r_mem_we <= 1'b0;
         if (w_take_sync) begin
            cpu_run  <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
         end
         if (w_take_addr) begin
            r_frame_addr <= bus.in_data;
            r_sum        <= bus.in_data;
            r_waddr      <= ADDR_W'(bus.in_data & ADDR_MASK);
         end
         if (w_take_len) begin
            r_len_cnt <= bus.in_data;
            r_sum     <= r_sum + bus.in_data;
         end
         if (w_take_data) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_waddr;
            r_mem_wdata <= bus.in_data;
            r_waddr     <= r_waddr + 1'b1;
            r_len_cnt   <= r_len_cnt - 8'd1;
            r_sum       <= r_sum + bus.in_data;
         end
         if (w_take_csum) begin
            if (w_sum_match) begin
               cpu_run  <= 1'b1;
               entry_ip <= r_frame_addr;
               load_ok  <= 1'b1;
               load_err <= 1'b0;
            end else begin
               load_ok  <= 1'b0;
               load_err <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = r_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule
